// File: rtl/bit_vault_rf.sv
// Register file with one write port, two registered read ports and a self-zeroing sweep.
// Define BIT_VAULT_RF_BYPASS_EN to forward same-cycle write data to a matching read.
module bit_vault_rf #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  output logic              busy,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] data_out_a,
  output logic              rvalid_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] data_out_b,
  output logic              rvalid_b
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic IDLE  = 1'b0;
  localparam logic SWEEP = 1'b1;

  logic              state_r;
  logic [ADDR_W-1:0] ptr_r;
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] data_a_r;
  logic [DATA_W-1:0] data_b_r;
  logic              valid_a_r;
  logic              valid_b_r;
  logic              idle_s;
  logic              last_s;
  logic [DATA_W-1:0] rd_a_s;
  logic [DATA_W-1:0] rd_b_s;

  assign idle_s     = (state_r == IDLE);
  assign last_s     = (ptr_r == {ADDR_W{1'b1}});
  assign busy       = (state_r == SWEEP);
  assign data_out_a = data_a_r;
  assign data_out_b = data_b_r;
  assign rvalid_a   = valid_a_r;
  assign rvalid_b   = valid_b_r;

  // Read data selection, optionally forwarding the write of the same cycle
  always_comb begin
    rd_a_s = mem_r[raddr_a];
    rd_b_s = mem_r[raddr_b];
`ifdef BIT_VAULT_RF_BYPASS_EN
    if (write_enable && (waddr == raddr_a)) begin
      rd_a_s = data_in;
    end else begin
      rd_a_s = mem_r[raddr_a];
    end
    if (write_enable && (waddr == raddr_b)) begin
      rd_b_s = data_in;
    end else begin
      rd_b_s = mem_r[raddr_b];
    end
`endif
  end

  // Sweep FSM: reset lands in SWEEP so the array is zeroed before first use
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= SWEEP;
      ptr_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (clear) begin
            state_r <= SWEEP;
            ptr_r   <= '0;
          end
        end
        SWEEP: begin
          ptr_r <= ptr_r + ADDR_W'(1);
          if (last_s) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= SWEEP;
          ptr_r   <= '0;
        end
      endcase
    end
  end

  // Storage array: sweep zeroing owns the write port while busy
  always_ff @(posedge clk) begin
    if (state_r == SWEEP) begin
      mem_r[ptr_r] <= '0;
    end else if (write_enable) begin
      mem_r[waddr] <= data_in;
    end
  end

  // Registered read ports; data holds when no read is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_a_r  <= '0;
      data_b_r  <= '0;
      valid_a_r <= 1'b0;
      valid_b_r <= 1'b0;
    end else begin
      valid_a_r <= re_a & idle_s;
      valid_b_r <= re_b & idle_s;
      if (re_a && idle_s) begin
        data_a_r <= rd_a_s;
      end
      if (re_b && idle_s) begin
        data_b_r <= rd_b_s;
      end
    end
  end

endmodule

// File: tb/tb_bit_vault_rf.sv
// Randomized self-checking bench for bit_vault_rf against a behavioural array model.
module tb_bit_vault_rf;

`ifdef BIT_VAULT_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk, rst, clear, busy, write_enable, re_a, re_b, rvalid_a, rvalid_b;
  logic [3:0] waddr, raddr_a, raddr_b;
  logic [7:0] data_in, data_out_a, data_out_b;

  logic busy2, we2, re_a2, re_b2, rvalid_a2, rvalid_b2;
  logic [5:0] waddr2, raddr_a2, raddr_b2;
  logic [31:0] data_in2, data_out_a2, data_out_b2;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem_m [16];
  int busy_cnt;
  logic [7:0] exp_da, exp_db;
  logic exp_va, exp_vb;

  bit_vault_rf dut (
    .clk(clk), .rst(rst), .clear(clear), .busy(busy),
    .write_enable(write_enable), .waddr(waddr), .data_in(data_in),
    .re_a(re_a), .raddr_a(raddr_a), .data_out_a(data_out_a), .rvalid_a(rvalid_a),
    .re_b(re_b), .raddr_b(raddr_b), .data_out_b(data_out_b), .rvalid_b(rvalid_b)
  );

  bit_vault_rf #(.DATA_W(32), .ADDR_W(6)) dut2 (
    .clk(clk), .rst(rst), .clear(1'b0), .busy(busy2),
    .write_enable(we2), .waddr(waddr2), .data_in(data_in2),
    .re_a(re_a2), .raddr_a(raddr_a2), .data_out_a(data_out_a2), .rvalid_a(rvalid_a2),
    .re_b(re_b2), .raddr_b(raddr_b2), .data_out_b(data_out_b2), .rvalid_b(rvalid_b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
    busy_cnt = 16;
    exp_da = 8'h00; exp_db = 8'h00; exp_va = 1'b0; exp_vb = 1'b0;
  endtask

  // Apply current inputs across one clock edge and advance the model.
  task automatic step();
    if (busy_cnt == 0) begin
      exp_va = re_a;
      exp_vb = re_b;
      if (re_a) exp_da = (BYP && write_enable && raddr_a == waddr) ? data_in : mem_m[raddr_a];
      if (re_b) exp_db = (BYP && write_enable && raddr_b == waddr) ? data_in : mem_m[raddr_b];
      if (write_enable) mem_m[waddr] = data_in;
      if (clear) begin
        for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
        busy_cnt = 16;
      end
    end else begin
      exp_va = 1'b0;
      exp_vb = 1'b0;
      busy_cnt--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clear = 1'b0; write_enable = 1'b0; re_a = 1'b0; re_b = 1'b0;
    waddr = 4'd0; raddr_a = 4'd0; raddr_b = 4'd0; data_in = 8'h00;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1 || rvalid_a !== 1'b0 || rvalid_b !== 1'b0 ||
        data_out_a !== 8'h00 || data_out_b !== 8'h00) begin
      errors++;
      $display("FAIL reset_state busy=%b rv=%b%b da=%h db=%h expected busy=1 rv=00 da=00 db=00",
               busy, rvalid_a, rvalid_b, data_out_a, data_out_b);
    end
    repeat (16) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) n++;
      checks++;
      if (busy !== (busy_cnt > 0)) begin
        errors++;
        $display("FAIL reset_busy_cycle%0d got=%b expected=%b", i, busy, busy_cnt > 0);
      end
      step();
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL reset_busy_len got=%0d expected=16", n);
    end
    for (int a = 0; a < 16; a++) begin
      re_a = 1'b1; raddr_a = 4'(a); re_b = 1'b1; raddr_b = 4'(15 - a);
      step();
      checks++;
      if (data_out_a !== 8'h00 || data_out_b !== 8'h00 || rvalid_a !== 1'b1 || rvalid_b !== 1'b1) begin
        errors++;
        $display("FAIL reset_zero addr%0d da=%h db=%h rv=%b%b expected 00 00 11",
                 a, data_out_a, data_out_b, rvalid_a, rvalid_b);
      end
    end
    idle_inputs();
  endtask

  task automatic test_write_read();
    write_enable = 1'b1; waddr = 4'd3; data_in = 8'hA5;
    step();
    idle_inputs();
    re_a = 1'b1; raddr_a = 4'd3; re_b = 1'b1; raddr_b = 4'd3;
    step();
    checks++;
    if (data_out_a !== 8'hA5 || data_out_b !== 8'hA5 || rvalid_a !== 1'b1 || rvalid_b !== 1'b1) begin
      errors++;
      $display("FAIL dual_read da=%h db=%h rv=%b%b expected a5 a5 11",
               data_out_a, data_out_b, rvalid_a, rvalid_b);
    end
    idle_inputs();
    step();
    checks++;
    if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0 || data_out_a !== 8'hA5 || data_out_b !== 8'hA5) begin
      errors++;
      $display("FAIL read_hold rv=%b%b da=%h db=%h expected 00 a5 a5",
               rvalid_a, rvalid_b, data_out_a, data_out_b);
    end
  endtask

  task automatic test_bypass();
    logic [7:0] want;
    write_enable = 1'b1; waddr = 4'd7; data_in = 8'h11;
    step();
    data_in = 8'h3C; re_a = 1'b1; raddr_a = 4'd7;
    step();
    want = BYP ? 8'h3C : 8'h11;
    checks++;
    if (data_out_a !== want || rvalid_a !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_rw got=%h rv=%b expected=%h rv=1", data_out_a, rvalid_a, want);
    end
    idle_inputs();
    re_a = 1'b1; raddr_a = 4'd7;
    step();
    checks++;
    if (data_out_a !== 8'h3C) begin
      errors++;
      $display("FAIL after_rw got=%h expected=3c", data_out_a);
    end
    idle_inputs();
  endtask

  task automatic test_clear_sweep();
    int n;
    for (int a = 0; a < 16; a++) begin
      write_enable = 1'b1; waddr = 4'(a); data_in = 8'hFF;
      step();
    end
    idle_inputs();
    clear = 1'b1;
    step();
    clear = 1'b0;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      write_enable = 1'b1; waddr = 4'd2; data_in = 8'h55;
      re_a = 1'b1; raddr_a = 4'($urandom_range(15)); re_b = 1'b1; raddr_b = 4'd2;
      clear = (i == 5);
      if (busy) n++;
      checks++;
      if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0) begin
        errors++;
        $display("FAIL sweep_rvalid cycle%0d rv=%b%b expected 00", i, rvalid_a, rvalid_b);
      end
      step();
    end
    idle_inputs();
    checks++;
    if (n != 16 || busy !== 1'b0 || rvalid_a !== 1'b0) begin
      errors++;
      $display("FAIL sweep_len busy_cycles=%0d busy_now=%b rv=%b expected 16 0 0", n, busy, rvalid_a);
    end
    for (int a = 0; a < 16; a++) begin
      re_a = 1'b1; raddr_a = 4'(a); re_b = 1'b1; raddr_b = 4'(a);
      step();
      checks++;
      if (data_out_a !== 8'h00 || data_out_b !== 8'h00 || rvalid_a !== 1'b1) begin
        errors++;
        $display("FAIL sweep_zero addr%0d da=%h db=%h rv=%b expected 00 00 1",
                 a, data_out_a, data_out_b, rvalid_a);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    int n;
    write_enable = 1'b1; waddr = 4'd9; data_in = 8'h77;
    step();
    idle_inputs();
    re_a = 1'b1; raddr_a = 4'd9;
    step();
    idle_inputs();
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (8) step();
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1 || rvalid_a !== 1'b0 || data_out_a !== 8'h00) begin
      errors++;
      $display("FAIL midsweep_reset busy=%b rv=%b da=%h expected 1 0 00", busy, rvalid_a, data_out_a);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) n++;
      step();
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL midsweep_busy_len got=%0d expected=16", n);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      write_enable = 1'($urandom_range(1));
      waddr = 4'($urandom_range(15));
      data_in = 8'($urandom);
      re_a = 1'($urandom_range(1));
      re_b = 1'($urandom_range(1));
      raddr_a = 4'($urandom_range(15));
      raddr_b = ($urandom_range(3) == 0) ? raddr_a : 4'($urandom_range(15));
      if ($urandom_range(3) == 0) raddr_a = waddr;
      clear = ($urandom_range(49) == 0);
      step();
      checks++;
      if (data_out_a !== exp_da || data_out_b !== exp_db || rvalid_a !== exp_va ||
          rvalid_b !== exp_vb || busy !== (busy_cnt > 0)) begin
        errors++;
        $display("FAIL random%0d da=%h db=%h rv=%b%b busy=%b expected %h %h %b%b %b",
                 i, data_out_a, data_out_b, rvalid_a, rvalid_b, busy,
                 exp_da, exp_db, exp_va, exp_vb, busy_cnt > 0);
      end
    end
    idle_inputs();
  endtask

  task automatic test_wide();
    int k;
    k = 0;
    while (busy2 && k < 200) begin
      step();
      k++;
    end
    checks++;
    if (busy2 !== 1'b0) begin
      errors++;
      $display("FAIL wide_busy_timeout busy=%b expected 0", busy2);
    end
    we2 = 1'b1; waddr2 = 6'd63; data_in2 = 32'hDEADBEEF;
    step();
    we2 = 1'b0;
    re_a2 = 1'b1; raddr_a2 = 6'd63; re_b2 = 1'b1; raddr_b2 = 6'd0;
    step();
    re_a2 = 1'b0; re_b2 = 1'b0;
    checks++;
    if (data_out_a2 !== 32'hDEADBEEF || data_out_b2 !== 32'h0 || rvalid_a2 !== 1'b1 || rvalid_b2 !== 1'b1) begin
      errors++;
      $display("FAIL wide_wrap a=%h b=%h rv=%b%b expected deadbeef 00000000 11",
               data_out_a2, data_out_b2, rvalid_a2, rvalid_b2);
    end
  endtask

  initial begin
    idle_inputs();
    we2 = 1'b0; waddr2 = 6'd0; data_in2 = 32'h0;
    re_a2 = 1'b0; raddr_a2 = 6'd0; re_b2 = 1'b0; raddr_b2 = 6'd0;
    test_reset();
    test_write_read();
    test_bypass();
    test_clear_sweep();
    test_reset_mid();
    test_random();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
